// File: rtl/triangle_assembler.sv
// triangle_assembler: groups a vertex stream into triangles (v0, v1, v2, color)
// and buffers completed triangles in a first-word-fall-through FIFO.
// Optional statistics counters are enabled by defining TRI_ASSEMBLER_STATS_EN;
// without it tri_count and drop_count are tied to zero.
// Output handshake: a triangle transfers on any cycle where tri_valid && tri_ready;
// the head entry is held stable while tri_valid && !tri_ready. The input side has
// no backpressure, so vertices are sampled on every cycle in which active is high.
module triangle_assembler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] vertex,
  input  logic [15:0] color,
  input  logic        new_triangle,
  input  logic        active,
  output logic        tri_valid,
  input  logic        tri_ready,
  output logic [47:0] tri_v0,
  output logic [47:0] tri_v1,
  output logic [47:0] tri_v2,
  output logic [15:0] tri_color,
  output logic        overflow,
  output logic        proto_err,
  output logic [15:0] tri_count,
  output logic [15:0] drop_count,
  output logic [1:0]  fsm_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [47:0]   v0_q, v0_d, v1_q, v1_d;
  logic [15:0]   color_q, color_d;
  logic          proto_err_q, proto_err_d;
  logic          overflow_q, overflow_d;
  logic          push_req;
  logic [159:0]  push_entry;

  logic [159:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, pop, push_ok, drop;
  logic [159:0]  head;

  // Assembly FSM: decides what the current vertex means and when a triangle completes
  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    color_d     = color_q;
    proto_err_d = proto_err_q;
    push_req    = 1'b0;
    case (state_q)
      SLOT0: begin
        if (active && new_triangle) begin
          v0_d    = vertex;
          color_d = color;
          state_d = SLOT1;
        end
      end
      SLOT1, SLOT2: begin
        if (!active) begin
          proto_err_d = 1'b1;
          state_d     = SLOT0;
        end else if (new_triangle) begin
          // Abort the partial triangle and restart with this vertex as v0
          proto_err_d = 1'b1;
          v0_d        = vertex;
          color_d     = color;
          state_d     = SLOT1;
        end else if (state_q == SLOT1) begin
          v1_d    = vertex;
          state_d = SLOT2;
        end else begin
          push_req = 1'b1;
          state_d  = SLOT0;
        end
      end
      default: state_d = SLOT0;
    endcase
  end

  // v2 is never stored in the assembler; it goes straight into the FIFO entry
  assign push_entry = {v0_q, v1_q, vertex, color_q};

  // FIFO control: a push into a full FIFO still succeeds when a pop frees a slot
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    pop        = tri_ready && !empty;
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    overflow_d = overflow_q | drop;
  end

  // State, pointer and sticky-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SLOT0;
      v0_q        <= '0;
      v1_q        <= '0;
      color_q     <= '0;
      proto_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      color_q     <= color_d;
      proto_err_q <= proto_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are meaningless while the occupancy says empty
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign tri_valid = !empty;
  assign tri_v0    = tri_valid ? head[159:112] : '0;
  assign tri_v1    = tri_valid ? head[111:64]  : '0;
  assign tri_v2    = tri_valid ? head[63:16]   : '0;
  assign tri_color = tri_valid ? head[15:0]    : '0;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign fsm_state = state_q;

`ifdef TRI_ASSEMBLER_STATS_EN
  logic [15:0] tri_count_q, tri_count_d, drop_count_q, drop_count_d;

  // Saturating statistics counters
  always_comb begin
    tri_count_d  = tri_count_q;
    drop_count_d = drop_count_q;
    if (push_ok && tri_count_q != 16'hFFFF) tri_count_d = tri_count_q + 16'd1;
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      tri_count_q  <= tri_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tri_count  = tri_count_q;
  assign drop_count = drop_count_q;
`else
  assign tri_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of triangles and FIFO.
module tb_triangle_assembler;
  localparam int DEPTH = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] vertex;
  logic [15:0] color;
  logic        new_triangle, active, tri_ready;
  logic        tri_valid, overflow, proto_err;
  logic [47:0] tri_v0, tri_v1, tri_v2;
  logic [15:0] tri_color, tri_count, drop_count;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  triangle_assembler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .vertex(vertex), .color(color),
    .new_triangle(new_triangle), .active(active), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
    .tri_color(tri_color), .overflow(overflow), .proto_err(proto_err),
    .tri_count(tri_count), .drop_count(drop_count), .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [159:0] exp_q[$];
  logic [47:0]  part_q[$];
  logic [15:0]  part_color;
  logic         m_over, m_perr;
  int           m_tc, m_dc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    part_color = '0;
    m_over = 0; m_perr = 0; m_tc = 0; m_dc = 0;
  endtask

  // one clock edge of the specified behaviour, from the inputs that were applied
  task automatic model_edge();
    logic         done;
    logic [159:0] t;
    done = 0;
    t = '0;
    if (active) begin
      if (new_triangle) begin
        if (part_q.size() > 0) m_perr = 1;
        part_q.delete();
        part_q.push_back(vertex);
        part_color = color;
      end else if (part_q.size() > 0) begin
        part_q.push_back(vertex);
        if (part_q.size() == 3) begin
          done = 1;
          t = {part_q[0], part_q[1], part_q[2], part_color};
          part_q.delete();
        end
      end
    end else begin
      if (part_q.size() > 0) m_perr = 1;
      part_q.delete();
    end
    if (tri_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (done) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(t);
        if (m_tc < 65535) m_tc++;
      end else begin
        m_over = 1;
        if (m_dc < 65535) m_dc++;
      end
    end
  endtask

  task automatic check_all();
    logic [159:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("tri_valid", 64'(tri_valid), 64'(exp_q.size() > 0));
    chk("tri_v0", 64'(tri_v0), 64'(h[159:112]));
    chk("tri_v1", 64'(tri_v1), 64'(h[111:64]));
    chk("tri_v2", 64'(tri_v2), 64'(h[63:16]));
    chk("tri_color", 64'(tri_color), 64'(h[15:0]));
    chk("overflow", 64'(overflow), 64'(m_over));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
`ifdef TRI_ASSEMBLER_STATS_EN
    chk("tri_count", 64'(tri_count), 64'(m_tc));
    chk("drop_count", 64'(drop_count), 64'(m_dc));
`else
    chk("tri_count", 64'(tri_count), 64'd0);
    chk("drop_count", 64'(drop_count), 64'd0);
`endif
  endtask

  // driver tasks
  task automatic step(input logic a, input logic n, input logic [47:0] v,
                      input logic [15:0] c, input logic r);
    rst = 0; active = a; new_triangle = n; vertex = v; color = c; tri_ready = r;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    active = $urandom_range(0, 1); new_triangle = $urandom_range(0, 1);
    vertex = {$urandom, $urandom}; color = $urandom; tri_ready = $urandom_range(0, 1);
    @(posedge clk);
    model_clear();
    #1 check_all();
  endtask

  function automatic logic [47:0] box_vtx(input int k);
    logic [15:0] x, z;
    x = 16'hFFF0 + 16'(k * 8);
    z = 16'h00F0 + 16'(k);
    return {x, 16'h0000, z};
  endfunction

  task automatic box_stream(input logic r);
    for (int k = 0; k < 30; k++)
      step(1'b1, (k % 3) == 0, box_vtx(k), 16'h0400 + 16'(k / 3), r);
  endtask

  task automatic rnd_tri(input logic [15:0] c, input logic r);
    step(1'b1, 1'b1, {$urandom, $urandom}, c, r);
    step(1'b1, 1'b0, {$urandom, $urandom}, $urandom, r);
    step(1'b1, 1'b0, {$urandom, $urandom}, $urandom, r);
  endtask

  initial begin
    model_clear();
    rst = 1; active = 0; new_triangle = 0; vertex = '0; color = '0; tri_ready = 0;
    do_reset();
    do_reset();
    chk("reset_fsm", 64'(fsm_state), 64'd0);

    // box stream drained continuously
    step(1'b1, 1'b1, box_vtx(0), 16'h0400, 1'b1);
    step(1'b1, 1'b0, box_vtx(1), 16'h0000, 1'b1);
    step(1'b1, 1'b0, box_vtx(2), 16'h0000, 1'b1);
    chk("first_v0", 64'(tri_v0), 64'h0000_FFF0_0000_00F0);
    chk("first_color", 64'(tri_color), 64'h0400);
    for (int k = 3; k < 30; k++)
      step(1'b1, (k % 3) == 0, box_vtx(k), 16'h0400 + 16'(k / 3), 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("box_proto_err", 64'(proto_err), 64'd0);
    chk("box_drained", 64'(tri_valid), 64'd0);

    // box stream with consumer stalled: 4 held, 6 dropped
    do_reset();
    box_stream(1'b0);
    chk("stall_valid", 64'(tri_valid), 64'd1);
    chk("stall_overflow", 64'(overflow), 64'd1);
`ifdef TRI_ASSEMBLER_STATS_EN
    chk("stall_drops", 64'(drop_count), 64'd6);
    chk("stall_tris", 64'(tri_count), 64'd4);
`endif
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0, '0, 1'b1);

    // new_triangle on the second vertex restarts assembly with the new color
    do_reset();
    step(1'b1, 1'b1, {$urandom, $urandom}, 16'h1111, 1'b0);
    step(1'b1, 1'b1, 48'h0001_0002_0003, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 48'h0004_0005_0006, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 48'h0007_0008_0009, 16'h0000, 1'b0);
    chk("restart_perr", 64'(proto_err), 64'd1);
    chk("restart_color", 64'(tri_color), 64'h2222);
    chk("restart_v2", 64'(tri_v2), 64'h0000_0007_0008_0009);

    // active dropped after v1, then a clean triangle
    do_reset();
    step(1'b1, 1'b1, {$urandom, $urandom}, 16'h3333, 1'b0);
    step(1'b1, 1'b0, {$urandom, $urandom}, 16'h0000, 1'b0);
    step(1'b0, 1'b0, {$urandom, $urandom}, 16'h0000, 1'b0);
    chk("abort_fsm", 64'(fsm_state), 64'd0);
    chk("abort_no_tri", 64'(tri_valid), 64'd0);
    rnd_tri(16'h4444, 1'b0);
    chk("abort_clean_color", 64'(tri_color), 64'h4444);

    // full FIFO with a pop on the completing edge: no drop
    do_reset();
    for (int k = 0; k < DEPTH; k++) rnd_tri(16'(k), 1'b0);
    step(1'b1, 1'b1, {$urandom, $urandom}, 16'h5555, 1'b0);
    step(1'b1, 1'b0, {$urandom, $urandom}, 16'h0000, 1'b0);
    step(1'b1, 1'b0, {$urandom, $urandom}, 16'h0000, 1'b1);
    chk("fullpop_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("fullpop_occupancy", 64'(tri_valid), 64'd0);

    // reset with two queued and one partial
    rnd_tri(16'h6666, 1'b0);
    rnd_tri(16'h7777, 1'b0);
    step(1'b1, 1'b1, {$urandom, $urandom}, 16'h8888, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    do_reset();
    chk("rst_valid", 64'(tri_valid), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_fsm", 64'(fsm_state), 64'd0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, 16'($urandom),
                (k % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power of two >= 2, number of assembled triangles buffered.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 vertex  in  48  {x,y,z}, each signed 16-bit, x in [47:32], z in [15:0].
REQ-005 color  in  16  triangle color; meaningful only in new_triangle cycles.
REQ-006 new_triangle  in  1  high in the cycle carrying a triangle's first vertex.
REQ-007 active  in  1  producer streaming; vertices are valid only while high.
REQ-008 tri_valid  out  1  output triangle available.
REQ-009 tri_ready  in  1  consumer accepts; transfer when tri_valid && tri_ready.
REQ-010 tri_v0, tri_v1, tri_v2  out  48 each  vertices in arrival order.
REQ-011 tri_color  out  16  color latched with v0.
REQ-012 overflow  out  1  sticky: a completed triangle was dropped because the FIFO was full.
REQ-013 proto_err  out  1  sticky: a partial triangle was aborted.
REQ-014 tri_count, drop_count  out  16 each  statistics counters (see Configuration).

Function
REQ-015 Assembly FSM states SLOT0, SLOT1, SLOT2; SLOT0 after reset.
REQ-016 SLOT0: when active && new_triangle, latch vertex as v0 and color, go to SLOT1; active cycles without new_triangle are ignored (no error).
REQ-017 SLOT1: active && !new_triangle latches v1 -> SLOT2; SLOT2: active && !new_triangle latches v2, completes triangle -> SLOT0.
REQ-018 In SLOT1/SLOT2, active && new_triangle aborts the partial triangle, sets proto_err, and restarts as SLOT0 behaviour in the same cycle (latches new v0/color -> SLOT1).
REQ-019 In SLOT1/SLOT2, active low aborts the partial triangle, sets proto_err, goes to SLOT0.
REQ-020 No input backpressure exists; input is sampled every cycle regardless of tri_ready.
REQ-021 Completion pushes {v0,v1,v2,color} into the FIFO at the same clock edge that v2 is sampled; tri_valid is high the following cycle if the FIFO was empty (latency 1 cycle from third vertex).
REQ-022 FIFO is first-word-fall-through; outputs reflect the head entry whenever tri_valid is high, and hold stable while tri_valid && !tri_ready.
REQ-023 Push succeeds if not full, or if full and a pop occurs in the same cycle.
REQ-024 Push when full without simultaneous pop: triangle dropped, FIFO unchanged, overflow set.
REQ-025 Pop on empty FIFO is ignored; tri_ready while !tri_valid has no effect.
REQ-026 Simultaneous push and pop on non-full FIFO leaves occupancy unchanged.
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter ranges 0..FIFO_DEPTH.

Reset
REQ-028 rst clears FSM to SLOT0, FIFO to empty, partial triangle discarded.
REQ-029 Reset values: tri_valid 0, tri_v0/v1/v2 0, tri_color 0, overflow 0, proto_err 0, tri_count 0, drop_count 0.
REQ-030 rst mid-assembly or with FIFO occupied discards all contents; no output transfer occurs in a reset cycle.

Configuration
REQ-031 Macro TRI_ASSEMBLER_STATS_EN defined: tri_count increments per successful push, drop_count per dropped triangle (REQ-024), both saturating at 16'hFFFF.
REQ-032 Macro undefined: counter logic is omitted and tri_count, drop_count are tied to 0; all other behaviour identical.

Verification
REQ-033 Drive 30-vertex box stream (lane 1, height 0, new_triangle every 3rd vertex), tri_ready=1 -> 10 triangles out; first tri_v0=48'hFFF0_0000_00F0, tri_color=16'h0400; proto_err=0.
REQ-034 Same stream, tri_ready=0 throughout, FIFO_DEPTH=4 -> tri_valid stays 1, 4 triangles held, overflow=1, drop_count=6, tri_count=4 (STATS_EN).
REQ-035 new_triangle asserted on 2nd vertex of a triangle -> proto_err=1, partial discarded, following 3 vertices form one valid triangle with the new color.
REQ-036 active dropped after v1 -> proto_err=1, no triangle output, FSM returns to SLOT0, next clean triangle assembles correctly.
REQ-037 FIFO full, tri_ready=1 in the cycle a triangle completes -> no drop, occupancy stays 4, overflow stays 0.
REQ-038 rst asserted with 2 triangles queued and one partial -> next cycle tri_valid=0, all flags and counters 0.
